perspective_divide: RTL and testbench

PERSPECTIVE_DIVIDE -- requirements
Module: perspective_divide

---
 rtl/perspective_divide.sv | 179 +++++++++++++++++
 tb/tb_perspective_divide.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/perspective_divide.sv
// Perspective divide: IEEE-754 x,y,z divided by w via a serial restoring mantissa divider.
// Define VIEWPORT_EN to add the px_out/py_out pixel mapping (two extra cycles).
module perspective_divide #(
   parameter int WIDTH_PX  = 1280,
   parameter int HEIGHT_PX = 720
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [3:0][31:0] pos,
   input  logic             valid_in,
   output logic             ready_out,
   output logic [2:0][31:0] ndc,
   output logic             clip_out,
   output logic             valid_out
`ifdef VIEWPORT_EN
   ,
   output logic [10:0]      px_out,
   output logic [10:0]      py_out
`endif
);

   typedef enum logic [2:0] {IDLE, CHECK, DIV, PACK, DONE} state_t;
   state_t r_state, w_next;

   logic [3:0][31:0] r_pos;
   logic [1:0]       r_comp;
   logic [4:0]       r_cnt;
   logic [24:0]      r_rem, r_q;
   logic [2:0][31:0] r_res;
   logic             r_ovf;

   logic             w_accept, w_clip_in, w_clip, w_exit, w_ge, w_ovf;
   logic [31:0]      w_num, w_den, w_quot;
   logic [23:0]      w_dm;
   logic [22:0]      w_frac;
   logic signed [9:0] w_exp;

   assign w_accept = valid_in && ready_out;
   assign w_den    = r_pos[0];
   assign w_dm     = {1'b1, w_den[22:0]};
   assign w_num    = r_pos[2'd3 - r_comp];
   assign w_ge     = r_rem >= {1'b0, w_dm};
   assign w_clip   = w_clip_in || r_ovf;

   // w must be a positive normal; x/y/z only need to be finite
   assign w_clip_in = (w_den[30:23] == 8'h00) || w_den[31] || (w_den[30:23] == 8'hff) ||
                      (r_pos[3][30:23] == 8'hff) || (r_pos[2][30:23] == 8'hff) ||
                      (r_pos[1][30:23] == 8'hff);

   // quotient lies in (0.5, 2): q[24] is the integer bit, otherwise normalize by one
   always_comb begin
      w_exp  = $signed({2'b00, w_num[30:23]}) - $signed({2'b00, w_den[30:23]}) + 10'sd127
               - (r_q[24] ? 10'sd0 : 10'sd1);
      w_frac = r_q[24] ? r_q[23:1] : r_q[22:0];
      w_ovf  = (w_num[30:23] != 8'h00) && (w_exp >= 10'sd255);
      w_quot = 32'h0;
      if ((w_num[30:23] != 8'h00) && (w_exp > 10'sd0) && !w_ovf)
         w_quot = {w_num[31] ^ w_den[31], w_exp[7:0], w_frac};
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) r_state <= IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = CHECK;
         CHECK:   w_next = w_clip_in ? DONE : DIV;
         DIV:     if (r_cnt == 5'd24) w_next = PACK;
         PACK:    w_next = (r_comp == 2'd2) ? DONE : DIV;
         DONE:    if (w_exit) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

`ifdef VIEWPORT_EN
   logic [1:0]  r_vp;
   logic [17:0] r_tx, r_ty;
   logic [10:0] r_pxc, r_pyc;
   logic [31:0] w_pxf, w_pyf;

   // returns 1 +/- ndc in Q2.16, with ndc saturated to [-1, 1]
   function automatic logic [17:0] one_pm(input logic [31:0] f, input logic flip);
      logic [16:0] mag;
      logic [7:0]  sh;
      if (f[30:23] >= 8'd127) mag = 17'h10000;
      else begin
         sh  = 8'd134 - f[30:23];
         mag = (sh >= 8'd24) ? 17'd0 : 17'({1'b1, f[22:0]} >> sh);
      end
      if (f[31] ^ flip) return 18'h10000 - {1'b0, mag};
      else              return 18'h10000 + {1'b0, mag};
   endfunction

   assign w_pxf = (32'(r_tx) * 32'(WIDTH_PX))  >> 17;
   assign w_pyf = (32'(r_ty) * 32'(HEIGHT_PX)) >> 17;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_vp <= '0; r_tx <= '0; r_ty <= '0; r_pxc <= '0; r_pyc <= '0;
      end else if (r_state != DONE) begin
         r_vp <= '0;
      end else begin
         r_vp <= r_vp + 2'd1;
         if (r_vp == 2'd0) begin
            r_tx <= one_pm(r_res[2], 1'b0);
            r_ty <= one_pm(r_res[1], 1'b1);
         end
         if (r_vp == 2'd1) begin
            r_pxc <= (w_pxf > 32'(WIDTH_PX - 1))  ? 11'(WIDTH_PX - 1)  : w_pxf[10:0];
            r_pyc <= (w_pyf > 32'(HEIGHT_PX - 1)) ? 11'(HEIGHT_PX - 1) : w_pyf[10:0];
         end
      end
   end
`endif

   always_comb begin
      ready_out = (r_state == IDLE);
`ifdef VIEWPORT_EN
      w_exit    = (r_state == DONE) && (w_clip || (r_vp == 2'd2));
`else
      w_exit    = (r_state == DONE);
`endif
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_pos <= '0; r_comp <= '0; r_cnt <= '0; r_rem <= '0; r_q <= '0;
         r_res <= '0; r_ovf <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_pos  <= pos;
               r_comp <= 2'd0;
               r_ovf  <= 1'b0;
            end
            CHECK: begin
               r_rem <= {2'b01, w_num[22:0]};
               r_cnt <= 5'd0;
            end
            DIV: begin
               r_cnt <= r_cnt + 5'd1;
               r_q   <= {r_q[23:0], w_ge};
               r_rem <= w_ge ? (r_rem - {1'b0, w_dm}) << 1 : r_rem << 1;
            end
            PACK: begin
               r_res[2'd2 - r_comp] <= w_quot;
               r_ovf  <= r_ovf || w_ovf;
               r_comp <= r_comp + 2'd1;
               r_cnt  <= 5'd0;
               r_rem  <= {2'b01, r_pos[2'd2 - r_comp][22:0]};
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid_out <= 1'b0; clip_out <= 1'b0; ndc <= '0;
`ifdef VIEWPORT_EN
         px_out <= '0; py_out <= '0;
`endif
      end else begin
         valid_out <= w_exit;
         if (w_exit) begin
            clip_out <= w_clip;
            ndc      <= w_clip ? '0 : r_res;
`ifdef VIEWPORT_EN
            px_out   <= w_clip ? 11'd0 : r_pxc;
            py_out   <= w_clip ? 11'd0 : r_pyc;
`endif
         end
      end
   end

endmodule

// File: tb/tb_perspective_divide.sv
// Scoreboard bench for perspective_divide: directed vertices, expected results queued at issue.
module tb_perspective_divide;
`ifdef VIEWPORT_EN
   localparam int LAT = 82;
`else
   localparam int LAT = 80;
`endif

   logic             clk_in = 1'b0;
   logic             rst_in;
   logic [3:0][31:0] pos;
   logic             valid_in;
   logic             ready_out;
   logic [2:0][31:0] ndc;
   logic             clip_out;
   logic             valid_out;
`ifdef VIEWPORT_EN
   logic [10:0]      px_out, py_out;
`endif

   perspective_divide #(.WIDTH_PX(1280), .HEIGHT_PX(720)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .pos(pos), .valid_in(valid_in),
      .ready_out(ready_out), .ndc(ndc), .clip_out(clip_out), .valid_out(valid_out)
`ifdef VIEWPORT_EN
      , .px_out(px_out), .py_out(py_out)
`endif
   );

   typedef struct {
      logic [2:0][31:0] ndc;
      logic             clip;
      int               px;
      int               py;
      int               cyc;
   } exp_t;

   exp_t sbq[$];
   exp_t m_e;
   int   checks = 0, errors = 0, cyc = 0;
   int   a1, a2, a3, rel;

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // monitor: pops one expectation per valid_out pulse
   always @(negedge clk_in) begin
      if (rst_in && valid_out) begin
         if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid_out: got valid_out=1 expected none (cycle %0d)", cyc);
         end else begin
            m_e = sbq.pop_front();
            chk("ndc", 96'(ndc), 96'(m_e.ndc));
            chk("clip_out", 96'(clip_out), 96'(m_e.clip));
            chk("latency_cycle", 96'(cyc), 96'(m_e.cyc));
`ifdef VIEWPORT_EN
            chk("px_out", 96'(px_out), 96'(m_e.px));
            chk("py_out", 96'(py_out), 96'(m_e.py));
`endif
         end
      end
   end

   task automatic send(input logic [31:0] x, y, z, w,
                       input logic [31:0] ex, ey, ez, input logic ec,
                       input int epx, epy, lat, input bit push, output int acc);
      exp_t e;
      int n = 0;
      acc = -1;
      @(negedge clk_in);
      while (!ready_out && n < 300) begin
         @(negedge clk_in);
         n++;
      end
      if (!ready_out) begin
         checks++; errors++;
         $display("FAIL ready_timeout: got ready_out=0 expected 1 within 300 cycles");
         return;
      end
      pos = {x, y, z, w};
      valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      acc = cyc;
      valid_in = 1'b0;
      chk("ready_low_after_accept", 96'(ready_out), 96'(0));
      if (push) begin
         e.ndc = {ex, ey, ez}; e.clip = ec; e.px = epx; e.py = epy; e.cyc = acc + lat;
         sbq.push_back(e);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_in = 1'b0; valid_in = 1'b0; pos = '0;
      #1;
      chk("reset_ready", 96'(ready_out), 96'(1));
      chk("reset_valid", 96'(valid_out), 96'(0));
      chk("reset_clip",  96'(clip_out),  96'(0));
      chk("reset_ndc",   96'(ndc),       96'(0));
      repeat (3) @(negedge clk_in);
      rst_in = 1'b1;

      send(32'h3f800000, 32'h3f800000, 32'h0, 32'h3f800000,
           32'h3f800000, 32'h3f800000, 32'h0, 1'b0, 1279, 0, LAT, 1, a1);
      send(32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h40000000,
           32'h3f000000, 32'h3f000000, 32'h3f000000, 1'b0, 960, 180, LAT, 1, a1);
      // valid_in while busy must be dropped
      repeat (10) @(negedge clk_in);
      chk("busy_ready_low", 96'(ready_out), 96'(0));
      pos = {32'h40400000, 32'h40400000, 32'h40400000, 32'h3f800000};
      valid_in = 1'b1;
      @(negedge clk_in);
      valid_in = 1'b0;
      // next vertex lands in the valid_out cycle
      send(32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h00000000,
           32'h0, 32'h0, 32'h0, 1'b1, 0, 0, 2, 1, a2);
      chk("back_to_back_accept", 96'(a2), 96'(a1 + LAT + 1));
      send(32'h3f800000, 32'h3f800000, 32'h3f800000, 32'hbf800000,
           32'h0, 32'h0, 32'h0, 1'b1, 0, 0, 2, 1, a2);
      send(32'h7f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000,
           32'h0, 32'h0, 32'h0, 1'b1, 0, 0, 2, 1, a2);
      send(32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h00400000,
           32'h0, 32'h0, 32'h0, 1'b1, 0, 0, 2, 1, a2);
      send(32'h7f000000, 32'h0, 32'h0, 32'h00800000,
           32'h0, 32'h0, 32'h0, 1'b1, 0, 0, LAT, 1, a2);
      send(32'hc0400000, 32'h0, 32'h0, 32'h3f800000,
           32'hc0400000, 32'h0, 32'h0, 1'b0, 0, 360, LAT, 1, a2);
      send(32'h00800000, 32'h00000001, 32'h3f800000, 32'h42000000,
           32'h0, 32'h0, 32'h3d000000, 1'b0, 640, 360, LAT, 1, a2);
      send(32'h3f800000, 32'h40400000, 32'hbf800000, 32'h3fc00000,
           32'h3f2aaaaa, 32'h40000000, 32'hbf2aaaaa, 1'b0, 1066, 0, LAT, 1, a2);

      // abort an operation with reset at cycle 40
      send(32'h3f800000, 32'h3f800000, 32'h0, 32'h3f800000,
           32'h0, 32'h0, 32'h0, 1'b0, 0, 0, LAT, 0, a3);
      repeat (40) @(posedge clk_in);
      #1 rst_in = 1'b0;
      #1;
      chk("abort_ready", 96'(ready_out), 96'(1));
      chk("abort_valid", 96'(valid_out), 96'(0));
      chk("abort_clip",  96'(clip_out),  96'(0));
      chk("abort_ndc",   96'(ndc),       96'(0));
      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b1;
      rel = cyc;
      send(32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h40000000,
           32'h3f000000, 32'h3f000000, 32'h3f000000, 1'b0, 960, 180, LAT, 1, a2);
      chk("accept_after_release", 96'(a2), 96'(rel + 1));

      n = 0;
      while (sbq.size() != 0 && n < 400) begin
         @(negedge clk_in);
         n++;
      end
      if (sbq.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      end
      repeat (100) @(negedge clk_in);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
